// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op-code constants and output-stage state encoding for logic_unit_pipe
package logic_unit_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
    localparam logic [OP_W-1:0] OP_AND  = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;
endpackage

// File: rtl/logic_op_eval.sv
// logic_op_eval: combinational bitwise operation with zero and parity flags
module logic_op_eval import logic_unit_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);
    always_comb begin
        case (op)
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            default: result = a;
        endcase
    end
    assign zero   = ~|result;
    assign parity = ^result;
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with valid/ready handshake,
// 2-entry skid buffer, status flags and a completed-operation counter
module logic_unit_pipe import logic_unit_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    input  logic             clr_count,
    output logic [CNT_W-1:0] op_count
);
    state_e           r_state, w_next;
    logic             r_in_ready;
    logic [WIDTH+1:0] r_out, r_skid;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_res;
    logic             w_zero, w_par, w_acc, w_hs;
    logic             w_load_out, w_load_skid, w_skid_to_out;
    logic [WIDTH+1:0] w_ent;

    // Evaluated straight from the handshake inputs so the result lands one cycle after acceptance
    logic_op_eval #(.WIDTH(WIDTH)) u_eval (
        .a(in_a), .b(in_b), .op(in_op),
        .result(w_res), .zero(w_zero), .parity(w_par)
    );

    assign w_ent     = {w_par, w_zero, w_res};
    assign w_acc     = in_valid & r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_hs      = out_valid & out_ready;

    always_comb begin
        w_next        = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_next     = w_acc ? ST_ONE : ST_EMPTY;
                w_load_out = w_acc;
            end
            ST_ONE: begin
                w_next      = w_acc ? (out_ready ? ST_ONE : ST_FULL) : (out_ready ? ST_EMPTY : ST_ONE);
                w_load_out  = w_acc & out_ready;
                w_load_skid = w_acc & ~out_ready;
            end
            ST_FULL: begin
                w_next        = out_ready ? ST_ONE : ST_FULL;
                w_skid_to_out = out_ready;
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_FULL);
            if (w_load_out)
                r_out <= w_ent;
            else if (w_skid_to_out)
                r_out <= r_skid;
            if (w_load_skid)
                r_skid <= w_ent;
            r_cnt <= clr_count ? '0 : (w_hs ? r_cnt + 1'b1 : r_cnt);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_result = r_out[WIDTH-1:0];
    assign out_zero   = r_out[WIDTH];
    assign out_parity = r_out[WIDTH+1];
    assign op_count   = r_cnt;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: randomized and directed checks of logic_unit_pipe against a queue-based model
module tb_logic_unit_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0, out_result;
    logic [2:0] in_op = '0;
    logic       out_zero, out_parity, clr_count = 1'b0;
    logic [3:0] op_count;

    logic [7:0] q[$];
    logic [3:0] m_cnt = '0;
    logic       acc, hs;
    int         n_cmp = 0, n_bad = 0;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_parity(out_parity), .clr_count(clr_count), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return ~a;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs against the model just before the edge, then advance the model
    task automatic step();
        @(negedge clk);
        if (q.size() > 0) begin
            chk("res", out_result, q[0]);
            chk("zero", out_zero, q[0] == 8'h00);
            chk("par", out_parity, ^q[0]);
        end
        chk("ovalid", out_valid, q.size() > 0);
        chk("iready", in_ready, q.size() < 2);
        chk("cnt", op_count, m_cnt);
        acc = in_valid && (q.size() < 2);
        hs  = out_ready && (q.size() > 0);
        if (hs) void'(q.pop_front());
        if (acc) q.push_back(ref_op(in_op, in_a, in_b));
        m_cnt = clr_count ? 4'd0 : (hs ? m_cnt + 4'd1 : m_cnt);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step();
        chk("send_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #12;
        chk("rst_ovalid", out_valid, 0);
        chk("rst_iready", in_ready, 1);
        chk("rst_res", out_result, 8'h00);
        chk("rst_zero", out_zero, 0);
        chk("rst_par", out_parity, 0);
        chk("rst_cnt", op_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        out_ready = 1'b1;
        send(8'hA5, 8'h00, 3'b000);
        chk("not_res", out_result, 8'h5A);
        chk("not_zero", out_zero, 0);
        chk("not_par", out_parity, 0);
        step();
        chk("not_cnt", op_count, 1);

        send(8'h3C, 8'h3C, 3'b011);
        chk("xor_res", out_result, 8'h00);
        chk("xor_zero", out_zero, 1);
        chk("xor_par", out_parity, 0);
        send(8'hF0, 8'h0F, 3'b100);
        chk("nand_res", out_result, 8'hFF);
        chk("nand_zero", out_zero, 0);
        chk("nand_par", out_parity, 0);
        step();

        clr_count = 1'b1; step(); clr_count = 1'b0;
        out_ready = 1'b0;
        send(8'h01, 8'h00, 3'b111);
        send(8'h02, 8'h00, 3'b111);
        chk("bp_iready", in_ready, 0);
        in_a = 8'h03; in_op = 3'b111; in_valid = 1'b1;
        repeat (3) step();
        chk("bp_hold", out_result, 8'h01);
        out_ready = 1'b1;
        send(8'h03, 8'h00, 3'b111);
        drain();
        chk("bp_cnt", op_count, 3);

        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'(i % 8);
            step();
            chk("tp_acc", acc, 1);
        end
        drain();

        clr_count = 1'b1; step(); clr_count = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
            step();
        end
        in_valid = 1'b0; step();
        chk("wrap", op_count, 0);
        in_valid = 1'b1;
        repeat (5) step();
        in_valid = 1'b0; step();
        chk("cnt5", op_count, 5);
        in_valid = 1'b1; step();
        in_valid = 1'b0; clr_count = 1'b1; step(); clr_count = 1'b0;
        chk("clr_win", op_count, 0);

        send(8'h77, 8'h11, 3'b010);
        step();
        out_ready = 1'b0;
        send(8'h10, 8'h20, 3'b001);
        send(8'h30, 8'h40, 3'b010);
        chk("full_iready", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ovalid", out_valid, 0);
        chk("arst_iready", in_ready, 1);
        chk("arst_cnt", op_count, 0);
        chk("arst_res", out_result, 8'h00);
        q.delete();
        m_cnt = '0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        begin
            logic [7:0] a, b;
            logic [2:0] op;
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            send(a, b, op);
            chk("post_rst", out_result, ref_op(op, a, b));
        end
        step();

        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clr_count = ($urandom_range(0, 31) == 0);
            in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
            step();
        end
        clr_count = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised WIDTH-bit bitwise logic unit, the multi-bit, multi-mode successor to the 1-bit inverter cell in the ALU.
- Evaluates one of eight bitwise operations on operands A/B.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer.
- Adds zero and parity status flags and a completed-operation counter.
- Sits between the ALU operand mux and the ALU result mux.

Parameters:
WIDTH, 32, operand/result width in bits (>=1)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  unit can accept (registered)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored for NOT, PASS)
in_op  input  3  operation select
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  operation result
out_zero  output  1  1 when out_result == 0
out_parity  output  1  XOR-reduction of out_result
clr_count  input  1  synchronous clear of op_count
op_count  output  CNT_W  count of output handshakes, wraps

Behaviour:
- Reset (async, rst=1): out_valid=0, out_result=0, out_zero=0, out_parity=0, op_count=0, skid empty, in_ready=1.
- Op encoding:
  - 000 NOT A; 001 A&B; 010 A|B; 011 A^B
  - 100 ~(A&B); 101 ~(A|B); 110 ~(A^B); 111 PASS A
  - All codes are defined; there is no illegal op.
- Operands and op are captured only on input handshake (in_valid & in_ready); the result is computed combinationally from the captured values.
- Flags are computed from the result at load time and stored alongside it, so they always match out_result.
- Latency: the result appears at the output 1 cycle after acceptance when the output stage is empty or draining. Throughput is 1 per cycle under continuous out_ready.
- Output stage/skid states:
  - EMPTY: out_valid=0, skid empty.
  - ONE: out_valid=1, skid empty.
  - FULL: out_valid=1, skid holds a result.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + out_ready -> ONE (new result replaces old).
  - ONE + accept + !out_ready -> FULL (new result goes to skid).
  - ONE + no accept + out_ready -> EMPTY.
  - FULL + out_ready -> ONE (skid moves to output).
  - FULL + !out_ready -> FULL (hold).
- in_ready = skid empty, registered: it drops the cycle after entering FULL and rises the cycle after leaving FULL. No accept occurs in FULL.
- While out_valid=1 && out_ready=0: out_result, out_zero and out_parity are held stable. out_valid never drops without a handshake.
- Ordering is strictly FIFO; no result is dropped or duplicated.
- op_count increments by 1 on each output handshake (out_valid & out_ready) and wraps from 2^CNT_W-1 to 0.
- clr_count=1 sets op_count to 0 next cycle. If clr_count and a handshake coincide, clear wins (count=0).
- Reset asserted mid-operation discards the output and skid contents immediately. No partial results appear after release.
- in_valid while in_ready=0 has no effect; the upstream must hold the data.

Decomposition:
- Package logic_unit_pkg: op-code constants (OP_NOT..OP_PASS), op-select width constant 3.
- One combinational sub-module: logic_op_eval (WIDTH param; inputs a, b, op; outputs result, zero, parity). Instantiated once at the skid/output load path.
- The handshake, skid and counter logic stay in logic_unit_pipe.

Test Plan (WIDTH=8, CNT_W=4 unless noted):
- NOT: A=8'hA5, op=000, out_ready=1 -> next cycle out_result=8'h5A, zero=0, parity=0, op_count=1.
- XOR zero: A=B=8'h3C, op=011 -> out_result=8'h00, zero=1, parity=0. Then NAND A=8'hF0, B=8'h0F -> 8'hFF, parity=0, zero=0.
- Backpressure: out_ready=0; send 8'h01 then 8'h02 (PASS). in_ready=0 from the cycle after the second accept; third item 8'h03 is held. Raise out_ready -> outputs 01, 02, 03 in order, none lost, op_count=3.
- Full throughput: out_ready=1, in_valid=1 for 10 cycles, ops cycling 000..111 -> 10 results on 10 consecutive cycles after 1-cycle latency, each matching the expected value.
- Counter: 16 handshakes -> op_count=0 (wrap). Then clr_count coincident with a handshake at op_count=5 -> op_count=0.
- Async reset: assert rst mid-cycle while in FULL -> out_valid=0 and in_ready=1 immediately (before the next edge), op_count=0. After release, the first accepted op produces a correct result after 1 cycle.
